// File: rtl/ab_ff_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ab_ff_pkg
// Description : Shared types and the a/b cell next-state function.
// Revision    : 1.0 - initial release
// ============================================================================
package ab_ff_pkg;

   typedef enum logic [1:0] {
      OP_HOLD = 2'b00,
      OP_CLR  = 2'b01,
      OP_TGL  = 2'b10,
      OP_SET  = 2'b11
   } ab_op_t;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   function automatic logic ab_next(input logic a, input logic b, input logic q);
      return (~a & ~b & q) | (a & b) | (a & ~q);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ab_ff_cell.sv
`default_nettype none
// ============================================================================
// Module      : ab_ff_cell
// Description : Single a/b-controlled flip-flop, updated only when en=1.
// Revision    : 1.0 - initial release
// ============================================================================
module ab_ff_cell
   import ab_ff_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic a,
   input  logic b,
   output logic q
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= 1'b0;
      end else if (en) begin
         q <= ab_next(a, b, q);
      end
   end

endmodule
`default_nettype wire

// File: rtl/ab_ff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ab_ff_bank_arbiter
// Description : Round-robin arbiter sharing a bank of a/b flip-flops between
//               NREQ requesters; one command per cycle, response one cycle later.
//               Optional owner lock enabled by defining AB_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ab_ff_bank_arbiter
   import ab_ff_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int NBITS = 8,
   parameter int IDXW  = $clog2(NBITS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [2*NREQ-1:0]    req_op,
   input  logic [IDXW*NREQ-1:0] req_idx,
`ifdef AB_ARB_LOCK_EN
   input  logic [NREQ-1:0]      req_lock,
`endif
   output logic [NREQ-1:0]      rsp_valid,
   output logic                 rsp_q,
   output logic                 rsp_err,
   output logic [NBITS-1:0]     q_bank
);

   localparam int c_ptrw = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [c_ptrw-1:0] r_rr_ptr;
   logic [NREQ-1:0]   w_eligible;
   logic [NREQ-1:0]   w_grant;
   logic [c_ptrw-1:0] w_gsel;
   logic              w_accept;
   ab_op_t            w_op;
   logic [IDXW-1:0]   w_idx;
   logic              w_in_range;
   logic              w_a;
   logic              w_b;
   logic              w_cur;
   logic              w_next;

`ifdef AB_ARB_LOCK_EN
   arb_state_t        r_state;
   logic [c_ptrw-1:0] r_owner;
`endif

   function automatic logic [c_ptrw-1:0] f_ptr_inc(input logic [c_ptrw-1:0] p);
      return (int'(p) == NREQ - 1) ? '0 : p + 1'b1;
   endfunction

   // While locked, only the owner may compete, even when it is idle.
   always_comb begin
      w_eligible = req_valid;
`ifdef AB_ARB_LOCK_EN
      if (r_state == LOCKED) begin
         w_eligible          = '0;
         w_eligible[r_owner] = req_valid[r_owner];
      end
`endif
   end

   always_comb begin
      int   p;
      logic found;
      p       = 0;
      found   = 1'b0;
      w_grant = '0;
      w_gsel  = '0;
      for (int k = 0; k < NREQ; k++) begin
         p = int'(r_rr_ptr) + k;
         if (p >= NREQ) p = p - NREQ;
         if (rst_n && !found && w_eligible[p]) begin
            found      = 1'b1;
            w_grant[p] = 1'b1;
            w_gsel     = c_ptrw'(p);
         end
      end
   end

   assign req_ready = w_grant;
   assign w_accept  = |w_grant;

   always_comb begin
      w_op  = OP_HOLD;
      w_idx = '0;
      for (int r = 0; r < NREQ; r++) begin
         if (w_grant[r]) begin
            w_op  = ab_op_t'(req_op[2*r +: 2]);
            w_idx = req_idx[IDXW*r +: IDXW];
         end
      end
   end

   assign w_in_range = (int'(w_idx) < NBITS);
   assign w_a        = (w_op == OP_TGL) || (w_op == OP_SET);
   assign w_b        = (w_op == OP_CLR) || (w_op == OP_SET);

   // Loop mux avoids indexing past the bank for out-of-range idx.
   always_comb begin
      w_cur = 1'b0;
      for (int i = 0; i < NBITS; i++) begin
         if (int'(w_idx) == i) w_cur = q_bank[i];
      end
   end

   assign w_next = ab_next(w_a, w_b, w_cur);

   generate
      for (genvar i = 0; i < NBITS; i++) begin : g_cell
         logic w_en;
         assign w_en = w_accept && w_in_range && (int'(w_idx) == i);
         ab_ff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (w_en),
            .a     (w_a),
            .b     (w_b),
            .q     (q_bank[i])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid <= '0;
         rsp_q     <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= w_grant;
         rsp_q     <= w_accept & w_in_range & w_next;
         rsp_err   <= w_accept & ~w_in_range;
      end
   end

   // In LOCKED the grant is always the owner, so granted+1 equals owner+1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
`ifdef AB_ARB_LOCK_EN
         r_state  <= ARB;
         r_owner  <= '0;
`endif
      end else if (w_accept) begin
         r_rr_ptr <= f_ptr_inc(w_gsel);
`ifdef AB_ARB_LOCK_EN
         case (r_state)
            ARB: begin
               if (req_lock[w_gsel]) begin
                  r_state <= LOCKED;
                  r_owner <= w_gsel;
               end
            end
            LOCKED: begin
               if (!req_lock[r_owner]) r_state <= ARB;
            end
            default: r_state <= ARB;
         endcase
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ab_ff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ab_ff_bank_arbiter
// Description : Scoreboard bench for ab_ff_bank_arbiter (NBITS=8 and NBITS=6).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ab_ff_bank_arbiter;

   localparam logic [1:0] HLD = 2'b00, CLR = 2'b01, TGL = 2'b10, SET = 2'b11;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic [1:0] req_valid = '0, req_ready, rsp_valid;
   logic [3:0] req_op = '0;
   logic [5:0] req_idx = '0;
   logic       rsp_q, rsp_err;
   logic [7:0] q_bank;

   logic [1:0] req_valid6 = '0, req_ready6, rsp_valid6;
   logic [3:0] req_op6 = '0;
   logic [5:0] req_idx6 = '0;
   logic       rsp_q6, rsp_err6;
   logic [5:0] q_bank6;

`ifdef AB_ARB_LOCK_EN
   logic [1:0] req_lock = '0;
   logic [1:0] req_lock6 = '0;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct { logic [1:0] v; logic q; logic e; logic [7:0] bank; } exp_t;
   exp_t sb8[$];
   exp_t sb6[$];
   exp_t m8, m6;

   always #5 clk = ~clk;

   ab_ff_bank_arbiter #(.NREQ(2), .NBITS(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_idx(req_idx),
`ifdef AB_ARB_LOCK_EN
      .req_lock(req_lock),
`endif
      .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_err(rsp_err), .q_bank(q_bank)
   );

   ab_ff_bank_arbiter #(.NREQ(2), .NBITS(6)) u_dut6 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid6), .req_ready(req_ready6),
      .req_op(req_op6), .req_idx(req_idx6),
`ifdef AB_ARB_LOCK_EN
      .req_lock(req_lock6),
`endif
      .rsp_valid(rsp_valid6), .rsp_q(rsp_q6), .rsp_err(rsp_err6), .q_bank(q_bank6)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   // Drive one cycle of requests, check the grant, queue the expected response.
   task automatic cmd(input logic [1:0] v, input logic [1:0] o0, input logic [2:0] i0,
                      input logic [1:0] o1, input logic [2:0] i1, input logic [1:0] er,
                      input logic eq, input logic ee, input logic [7:0] eb);
      req_valid = v;
      req_op    = {o1, o0};
      req_idx   = {i1, i0};
      #1;
      chk("req_ready", 32'(req_ready), 32'(er));
      if (er != 2'b00) sb8.push_back('{v: er, q: eq, e: ee, bank: eb});
      @(posedge clk); #1;
      req_valid = 2'b00;
   endtask

   task automatic cmd6(input logic [1:0] v, input logic [1:0] o0, input logic [2:0] i0,
                       input logic [1:0] o1, input logic [2:0] i1, input logic [1:0] er,
                       input logic eq, input logic ee, input logic [5:0] eb);
      req_valid6 = v;
      req_op6    = {o1, o0};
      req_idx6   = {i1, i0};
      #1;
      chk("req_ready6", 32'(req_ready6), 32'(er));
      if (er != 2'b00) sb6.push_back('{v: er, q: eq, e: ee, bank: {2'b00, eb}});
      @(posedge clk); #1;
      req_valid6 = 2'b00;
   endtask

   always @(negedge clk) begin
      if (rsp_valid !== 2'b00) begin
         if (sb8.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
         end else begin
            m8 = sb8.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(m8.v));
            chk("rsp_q",     32'(rsp_q),     32'(m8.q));
            chk("rsp_err",   32'(rsp_err),   32'(m8.e));
            chk("q_bank",    32'(q_bank),    32'(m8.bank));
         end
      end
   end

   always @(negedge clk) begin
      if (rsp_valid6 !== 2'b00) begin
         if (sb6.size() == 0) begin
            chk("unexpected_rsp6", 32'(rsp_valid6), 32'd0);
         end else begin
            m6 = sb6.pop_front();
            chk("rsp_valid6", 32'(rsp_valid6), 32'(m6.v));
            chk("rsp_q6",     32'(rsp_q6),     32'(m6.q));
            chk("rsp_err6",   32'(rsp_err6),   32'(m6.e));
            chk("q_bank6",    32'({2'b00, q_bank6}), 32'(m6.bank));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // Reset with every requester asserting valid
      req_valid = 2'b11;
      req_op    = {SET, SET};
      req_idx   = {3'd1, 3'd2};
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready",     32'(req_ready), 32'd0);
      chk("reset_q_bank",    32'(q_bank),    32'h00);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_q",     32'(rsp_q),     32'd0);
      rst_n     = 1'b1;
      req_valid = 2'b00;

      // First grant goes to req0, then set/toggle/toggle/clear/hold on idx 3
      cmd(2'b11, SET, 3'd3, HLD, 3'd0, 2'b01, 1'b1, 1'b0, 8'h08);
      cmd(2'b01, TGL, 3'd3, HLD, 3'd0, 2'b01, 1'b0, 1'b0, 8'h00);
      cmd(2'b01, TGL, 3'd3, HLD, 3'd0, 2'b01, 1'b1, 1'b0, 8'h08);
      cmd(2'b01, CLR, 3'd3, HLD, 3'd0, 2'b01, 1'b0, 1'b0, 8'h00);
      cmd(2'b01, HLD, 3'd3, HLD, 3'd0, 2'b01, 1'b0, 1'b0, 8'h00);

      // req1 alone (top index), leaving rr_ptr at 0; then alternating toggles on idx 0
      cmd(2'b10, HLD, 3'd0, SET, 3'd7, 2'b10, 1'b1, 1'b0, 8'h80);
      cmd(2'b11, TGL, 3'd0, TGL, 3'd0, 2'b01, 1'b1, 1'b0, 8'h81);
      cmd(2'b11, TGL, 3'd0, TGL, 3'd0, 2'b10, 1'b0, 1'b0, 8'h80);
      cmd(2'b11, TGL, 3'd0, TGL, 3'd0, 2'b01, 1'b1, 1'b0, 8'h81);
      cmd(2'b11, TGL, 3'd0, TGL, 3'd0, 2'b10, 1'b0, 1'b0, 8'h80);

      // Reset in the same cycle as a set of idx 5: nothing granted or applied
      rst_n = 1'b0;
      cmd(2'b01, SET, 3'd5, HLD, 3'd0, 2'b00, 1'b0, 1'b0, 8'h00);
      chk("rst_drop_q_bank",    32'(q_bank),    32'h00);
      chk("rst_drop_rsp_valid", 32'(rsp_valid), 32'd0);
      rst_n = 1'b1;
      cmd(2'b11, CLR, 3'd1, SET, 3'd2, 2'b01, 1'b0, 1'b0, 8'h00);
      cmd(2'b11, CLR, 3'd1, SET, 3'd2, 2'b10, 1'b1, 1'b0, 8'h04);

      // Out-of-range index on the 6-bit bank, plus its top valid index
      cmd6(2'b01, SET, 3'd6, HLD, 3'd0, 2'b01, 1'b0, 1'b1, 6'h00);
      cmd6(2'b01, SET, 3'd5, HLD, 3'd0, 2'b01, 1'b1, 1'b0, 6'h20);
      cmd6(2'b10, HLD, 3'd0, SET, 3'd7, 2'b10, 1'b0, 1'b1, 6'h20);
      cmd6(2'b01, TGL, 3'd5, HLD, 3'd0, 2'b01, 1'b0, 1'b0, 6'h00);

`ifdef AB_ARB_LOCK_EN
      // req1 locks; req0 is blocked until req1 releases
      req_lock = 2'b10;
      cmd(2'b10, HLD, 3'd0, SET, 3'd2, 2'b10, 1'b1, 1'b0, 8'h04);
      cmd(2'b11, TGL, 3'd0, HLD, 3'd2, 2'b10, 1'b1, 1'b0, 8'h04);
      cmd(2'b01, TGL, 3'd0, HLD, 3'd2, 2'b00, 1'b0, 1'b0, 8'h04);
      req_lock = 2'b00;
      cmd(2'b11, TGL, 3'd0, CLR, 3'd2, 2'b10, 1'b0, 1'b0, 8'h00);
      cmd(2'b11, TGL, 3'd0, CLR, 3'd2, 2'b01, 1'b1, 1'b0, 8'h01);
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("sb8_drained", 32'(sb8.size()), 32'd0);
      chk("sb6_drained", 32'(sb6.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
